chan_mux_rr: RTL and testbench

- Parametrised N-channel, W-bit registered channel multiplexer; next generation of the team's fixed 8:1 combinational mux.
- Adds a valid/ready handshake on every input and on the output, a one-deep output register, and two modes:
  - manual select;
  - round-robin scan over channels that have valid data.
- Sits between the per-channel datapaths (register file / ALU result lanes) and the shared display/output path.

---
 rtl/chan_mux_rr_pkg.sv | 19 +
 rtl/chan_mux_rr_pick.sv | 36 +++
 rtl/chan_mux_rr.sv | 110 +++++++++++
 tb/tb_chan_mux_rr.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_rr_pkg.sv
// rtl/chan_mux_rr_pkg.sv - shared mode encodings and width helper for the channel mux family
package chan_mux_rr_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Smallest r with 2**r >= v; used to tie the select width to the channel count.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/chan_mux_rr_pick.sv
// rtl/chan_mux_rr_pick.sv - combinational round-robin picker (rr_pick)
//
// Ports:
//   in_valid    [N-1:0]     per-channel request
//   rr_ptr      [SEL_W-1:0] first index to consider (always < N)
//   g           [SEL_W-1:0] first requesting index at or after rr_ptr, wrapping
//   grant_found             any request present
module rr_pick #(
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic [N-1:0]     in_valid,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic [SEL_W-1:0] g,
    output logic             grant_found
);

    always_comb begin
        int idx;
        g           = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int i = 0; i < N; i++) begin
            // Wrap by subtraction so the search never visits indices >= N.
            idx = int'(rr_ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_found && (idx < N) && in_valid[idx]) begin
                grant_found = 1'b1;
                g           = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// rtl/chan_mux_rr.sv - N-channel registered mux with valid/ready, manual or round-robin select
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mode                 0 = manual (sel), 1 = round-robin scan
//   sel       [SEL_W-1:0] manual channel index
//   in_data   [N*W-1:0]  channel k at [k*W +: W]
//   in_valid  [N-1:0]    per-channel valid
//   in_ready  [N-1:0]    per-channel accept, one-hot or zero
//   out_data  [W-1:0]    registered selected data
//   out_chan  [SEL_W-1:0] channel that produced out_data
//   out_valid            output holds a transfer
//   out_ready            downstream accept
module chan_mux_rr
    import chan_mux_rr_pkg::*;
#(
    parameter int W     = 4,
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    if (SEL_W != clog2(N)) begin : g_bad_sel_w
        $error("chan_mux_rr: SEL_W must equal clog2(N)");
    end
    if ((N < 2) || (N > 16)) begin : g_bad_n
        $error("chan_mux_rr: N must be in 2..16");
    end

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_g;
    logic             rr_found;
    logic [SEL_W-1:0] g;
    logic             grant_found;
    logic             space;
    logic             load;
    logic [W-1:0]     g_data;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .in_valid    (in_valid),
        .rr_ptr      (rr_ptr),
        .g           (rr_g),
        .grant_found (rr_found)
    );

    always_comb begin
        g           = rr_g;
        grant_found = rr_found;
        if (mode == MODE_MANUAL) begin
            g           = sel;
            grant_found = 1'b0;
            // A select past the last channel simply never grants.
            if (int'(sel) < N) begin
                grant_found = in_valid[sel];
            end
        end
    end

    assign space = !out_valid || out_ready;
    // rst_n gating keeps in_ready low for the whole reset pulse.
    assign load  = rst_n && space && grant_found;

    // Lane steering by compare rather than variable part-select: only the
    // granted lane reaches out_data, so undriven lanes cannot leak through.
    always_comb begin
        in_ready = '0;
        g_data   = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(g) == k) begin
                in_ready[k] = load;
                g_data      = in_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (load) begin
                out_data  <= g_data;
                out_chan  <= g;
                out_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    rr_ptr <= (int'(g) == N - 1) ? '0 : g + SEL_W'(1);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_chan_mux_rr.sv
// tb/tb_chan_mux_rr.sv - scoreboard bench for chan_mux_rr (N=8 main instance, N=6 select-range instance)
module tb_chan_mux_rr;

    logic        clk;
    logic        rst_n;

    logic        mode;
    logic [2:0]  sel;
    logic [31:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic [3:0]  out_data;
    logic [2:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic        d6_mode;
    logic [2:0]  d6_sel;
    logic [23:0] d6_in_data;
    logic [5:0]  d6_in_valid;
    logic [5:0]  d6_in_ready;
    logic [3:0]  d6_out_data;
    logic [2:0]  d6_out_chan;
    logic        d6_out_valid;
    logic        d6_out_ready;

    chan_mux_rr #(.W(4), .N(8), .SEL_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    chan_mux_rr #(.W(4), .N(6), .SEL_W(3)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (d6_mode),
        .sel       (d6_sel),
        .in_data   (d6_in_data),
        .in_valid  (d6_in_valid),
        .in_ready  (d6_in_ready),
        .out_data  (d6_out_data),
        .out_chan  (d6_out_chan),
        .out_valid (d6_out_valid),
        .out_ready (d6_out_ready)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [2:0] c;
    } item_t;

    item_t q[$];
    item_t pend_item;
    bit    pend_load;
    int    m_ptr;
    int    checks;
    int    errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the reference model decides from the arbitration
    // rules which channel (if any) the upcoming edge must accept.
    task automatic step(input logic m, input logic [2:0] s, input logic [7:0] v,
                        input logic [31:0] d, input logic r);
        int         g;
        bit         found;
        bit         sp;
        logic [7:0] exp_rdy;
        @(posedge clk);
        #1;
        if (pend_load) q.push_back(pend_item);
        pend_load = 0;
        mode      = m;
        sel       = s;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        sp    = (q.size() == 0) || r;
        found = 0;
        g     = 0;
        if (m == 1'b0) begin
            if (v[s]) begin
                found = 1;
                g     = int'(s);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                int k;
                k = (m_ptr + i) % 8;
                if (!found && v[k]) begin
                    found = 1;
                    g     = k;
                end
            end
        end
        exp_rdy = (sp && found) ? 8'(1 << g) : 8'h00;
        chk("in_ready", {24'h0, in_ready}, {24'h0, exp_rdy});
        if (sp && found) begin
            pend_load   = 1;
            pend_item.d = d[g*4 +: 4];
            pend_item.c = 3'(g);
            if (m) m_ptr = (g + 1) % 8;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        pend_load = 0;
        in_valid  = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {28'h0, out_data}, 32'h0);
        chk("rst_out_chan", {29'h0, out_chan}, 32'h0);
        chk("rst_in_ready", {24'h0, in_ready}, 32'h0);
        q.delete();
        m_ptr    = 0;
        in_valid = 8'h00;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("out_valid", {31'h0, out_valid}, {31'h0, (q.size() != 0)});
                if (out_valid && q.size() > 0) begin
                    chk("out_data", {28'h0, out_data}, {28'h0, q[0].d});
                    chk("out_chan", {29'h0, out_chan}, {29'h0, q[0].c});
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        m_ptr        = 0;
        pend_load    = 0;
        rst_n        = 1'b0;
        mode         = 1'b1;
        sel          = 3'd0;
        in_data      = 32'h0;
        in_valid     = 8'hFF;
        out_ready    = 1'b1;
        d6_mode      = 1'b0;
        d6_sel       = 3'd0;
        d6_in_data   = 24'h0;
        d6_in_valid  = 6'h00;
        d6_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_out_data", {28'h0, out_data}, 32'h0);
        chk("reset_out_chan", {29'h0, out_chan}, 32'h0);
        chk("reset_in_ready", {24'h0, in_ready}, 32'h0);
        in_valid = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;

        // Manual select of channel 5, then backpressure with new data waiting.
        step(1'b0, 3'd5, 8'h20, 32'h00A0_0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'd5, 8'h20, 32'h0030_0000, 1'b0);
            chk("bp_hold_data", {28'h0, out_data}, 32'hA);
            chk("bp_hold_chan", {29'h0, out_chan}, 32'h5);
        end
        step(1'b0, 3'd5, 8'h20, 32'h0030_0000, 1'b1);
        step(1'b0, 3'd5, 8'h00, 32'h0, 1'b1);
        step(1'b0, 3'd5, 8'h00, 32'h0, 1'b1);

        // Round-robin with every channel valid: 0..7 then 0 again.
        for (int i = 0; i < 9; i++) step(1'b1, 3'd0, 8'hFF, $urandom, 1'b1);

        // Park pointer at 6, then skip/wrap over channels 0 and 2.
        step(1'b1, 3'd0, 8'h20, $urandom, 1'b1);
        step(1'b1, 3'd0, 8'h05, $urandom, 1'b1);
        step(1'b1, 3'd0, 8'h05, $urandom, 1'b1);
        step(1'b1, 3'd0, 8'h09, $urandom, 1'b1);
        step(1'b1, 3'd0, 8'h00, 32'h0, 1'b1);
        step(1'b1, 3'd0, 8'h00, 32'h0, 1'b1);

        // Out-of-range select on the 6-channel build.
        @(posedge clk);
        #1;
        d6_mode      = 1'b0;
        d6_sel       = 3'd7;
        d6_in_valid  = 6'h3F;
        d6_in_data   = 24'h7000_00;
        d6_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("n6_sel7_in_ready", {26'h0, d6_in_ready}, 32'h0);
            @(negedge clk);
            chk("n6_sel7_out_valid", {31'h0, d6_out_valid}, 32'h0);
            @(posedge clk);
            #1;
        end
        d6_sel = 3'd5;
        #1;
        chk("n6_sel5_in_ready", {26'h0, d6_in_ready}, 32'h20);
        @(posedge clk);
        #1;
        d6_in_valid = 6'h00;
        chk("n6_sel5_out_valid", {31'h0, d6_out_valid}, 32'h1);
        chk("n6_sel5_out_chan", {29'h0, d6_out_chan}, 32'h5);
        chk("n6_sel5_out_data", {28'h0, d6_out_data}, 32'h7);

        // Randomized mix of modes, selects, valids and backpressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 $urandom, ($urandom_range(0, 3) != 0));
        end

        // Reset while an item is held under backpressure.
        step(1'b0, 3'd2, 8'h04, 32'h0000_0B00, 1'b1);
        step(1'b0, 3'd2, 8'h00, 32'h0, 1'b0);
        step(1'b0, 3'd2, 8'h00, 32'h0, 1'b0);
        reset_pulse();
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 8'hFF, $urandom, 1'b1);

        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        if (pend_load) q.push_back(pend_item);
        pend_load = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("drained", q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
